// File: rtl/reg_usb_stat_match_if.sv
// Register-bus bundle for reg_usb_stat_match. The bus master (usb_reg_main
// or a testbench) drives the address, strobes and write data. The matcher
// returns registered read data.
interface reg_usb_stat_match_if #(
  parameter int pBYTECNT_SIZE = 7
) ();
  logic [7:0]               reg_address;
  logic [pBYTECNT_SIZE-1:0] reg_bytecnt;
  logic [7:0]               read_data;
  logic [7:0]               write_data;
  logic                     reg_read;
  logic                     reg_write;
  logic                     reg_addrvalid;

  modport master (
    output reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
    input  read_data
  );

  modport slave (
    input  reg_address, reg_bytecnt, write_data, reg_read, reg_write, reg_addrvalid,
    output read_data
  );
endinterface

// File: rtl/reg_usb_stat_match.sv
// reg_usb_stat_match: pNUM_CHANNELS independent pattern/mask comparators on
// the front-end capture status bus. Each channel runs in first-match,
// last-match or edge-count mode and has a saturating match counter.
// Optional feature macro: STAT_MATCH_TIMESTAMP_EN builds the arm-relative
// timestamp counter and the per-channel captured timestamps. When the macro
// is undefined, TIMESTAMP reads return 0.
module reg_usb_stat_match #(
  parameter int         pNUM_CHANNELS    = 4,
  parameter int         pSTAT_WIDTH      = 5,
  parameter int         pCOUNT_WIDTH     = 16,
  parameter int         pTIMESTAMP_WIDTH = 24,
  parameter int         pBYTECNT_SIZE    = 7,
  parameter logic [1:0] pSELECT          = 2'b10
) (
  input  logic                     cwusb_clk,
  input  logic                     reset_i,
  reg_usb_stat_match_if.slave      bus,
  input  logic                     I_reg_arm,
  input  logic [pSTAT_WIDTH-1:0]   I_fe_capture_stat,
  output logic [pNUM_CHANNELS-1:0] O_match,
  output logic                     O_match_any,
  output logic [pNUM_CHANNELS-1:0] O_match_pulse,
  output logic                     selected
);

  typedef enum logic [1:0] {
    MODE_FIRST     = 2'd0,
    MODE_LAST      = 2'd1,
    MODE_EDGE      = 2'd2,
    MODE_FIRST_ALT = 2'd3
  } mode_e;

  logic [pSTAT_WIDTH-1:0]   pattern [pNUM_CHANNELS];
  logic [pSTAT_WIDTH-1:0]   mask    [pNUM_CHANNELS];
  mode_e                    mode    [pNUM_CHANNELS];
  logic [pSTAT_WIDTH-1:0]   value   [pNUM_CHANNELS];
  logic [pCOUNT_WIDTH-1:0]  count   [pNUM_CHANNELS];
  logic [pNUM_CHANNELS-1:0] flag, pulse, prev_hit;
  logic [pNUM_CHANNELS-1:0] hit, rise, capture, bump, wr_hit, ch_clear;

  logic                     arm_r, arm_edge, eval;
  logic [1:0]               ch_sel;
  logic [2:0]               reg_sel;
  logic [pBYTECNT_SIZE-1:0] bytecnt;
  logic [31:0]              bcnt;
  logic [1:0]               bsel;
  logic                     wr_en;
  logic [7:0]               rd_mux;
  logic [31:0]              cnt_ext, ts_ext;
  logic                     unused_bits;

  assign ch_sel      = bus.reg_address[4:3];
  assign reg_sel     = bus.reg_address[2:0];
  assign bytecnt     = bus.reg_bytecnt;
  assign bcnt        = 32'(bytecnt);
  assign bsel        = bcnt[1:0];
  assign selected    = bus.reg_addrvalid & (bus.reg_address[6:5] == pSELECT);
  assign wr_en       = selected & bus.reg_write;
  assign arm_edge    = I_reg_arm & ~arm_r;
  assign eval        = I_reg_arm & ~arm_edge;
  assign O_match     = flag;
  assign O_match_any = |flag;
  assign O_match_pulse = pulse;
  assign unused_bits = ^{bus.reg_address[7], bus.write_data};

`ifdef STAT_MATCH_TIMESTAMP_EN
  logic [pTIMESTAMP_WIDTH-1:0] ts_cnt;
  logic [pTIMESTAMP_WIDTH-1:0] ts_cap [pNUM_CHANNELS];

  // Free-running arm-relative timestamp: zeroed on the arm edge, saturates, holds while disarmed
  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      ts_cnt <= '0;
    end else if (arm_edge) begin
      ts_cnt <= '0;
    end else if (I_reg_arm && (ts_cnt != '1)) begin
      ts_cnt <= ts_cnt + pTIMESTAMP_WIDTH'(1);
    end
  end

  // Per-channel timestamp snapshot, taken whenever the channel captures a value
  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      for (int c = 0; c < pNUM_CHANNELS; c++) ts_cap[c] <= '0;
    end else begin
      for (int c = 0; c < pNUM_CHANNELS; c++) begin
        if (arm_edge || ch_clear[c]) ts_cap[c] <= '0;
        else if (capture[c])         ts_cap[c] <= ts_cnt;
      end
    end
  end
`else
  logic [pTIMESTAMP_WIDTH-1:0] unused_ts;
  assign unused_ts = '0;
`endif

  // Per-channel match, edge, capture and count-enable decisions plus write decode
  always_comb begin
    hit      = '0;
    rise     = '0;
    capture  = '0;
    bump     = '0;
    wr_hit   = '0;
    ch_clear = '0;
    for (int c = 0; c < pNUM_CHANNELS; c++) begin
      hit[c]  = eval && ((I_fe_capture_stat & mask[c]) == (pattern[c] & mask[c]));
      rise[c] = hit[c] & ~prev_hit[c];
      case (mode[c])
        MODE_LAST: begin
          capture[c] = hit[c];
          bump[c]    = hit[c];
        end
        MODE_EDGE: begin
          capture[c] = rise[c] & ~flag[c];
          bump[c]    = rise[c];
        end
        default: begin
          capture[c] = hit[c] & ~flag[c];
          bump[c]    = hit[c];
        end
      endcase
      wr_hit[c]   = wr_en && (int'(ch_sel) == c);
      ch_clear[c] = wr_hit[c] && (((reg_sel == 3'd0) && (bcnt == 32'd0)) || (reg_sel == 3'd5));
    end
  end

  // Arm-level history used to detect the arm edge
  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) arm_r <= 1'b0;
    else         arm_r <= I_reg_arm;
  end

  // Channel configuration writes and capture state; arm edge and clears discard any match that cycle
  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i) begin
      flag     <= '0;
      pulse    <= '0;
      prev_hit <= '0;
      for (int c = 0; c < pNUM_CHANNELS; c++) begin
        pattern[c] <= '0;
        mask[c]    <= '1;
        mode[c]    <= MODE_FIRST;
        value[c]   <= '0;
        count[c]   <= '0;
      end
    end else begin
      for (int c = 0; c < pNUM_CHANNELS; c++) begin
        if (wr_hit[c] && (reg_sel == 3'd0) && (bcnt == 32'd0)) pattern[c] <= bus.write_data[pSTAT_WIDTH-1:0];
        if (wr_hit[c] && (reg_sel == 3'd0) && (bcnt == 32'd1)) mask[c]    <= bus.write_data[pSTAT_WIDTH-1:0];
        if (wr_hit[c] && (reg_sel == 3'd1) && (bcnt == 32'd0)) mode[c]    <= mode_e'(bus.write_data[1:0]);
        if (arm_edge || ch_clear[c]) begin
          flag[c]     <= 1'b0;
          pulse[c]    <= 1'b0;
          prev_hit[c] <= 1'b0;
          value[c]    <= '0;
          count[c]    <= '0;
        end else begin
          prev_hit[c] <= hit[c];
          pulse[c]    <= capture[c] & ~flag[c];
          if (capture[c]) begin
            flag[c]  <= 1'b1;
            value[c] <= I_fe_capture_stat;
          end
          if (bump[c] && (count[c] != '1)) count[c] <= count[c] + pCOUNT_WIDTH'(1);
        end
      end
    end
  end

  // Register read mux; fields are zero-extended so bytes past a field's width read 0
  always_comb begin
    rd_mux  = 8'h00;
    cnt_ext = 32'd0;
    ts_ext  = 32'd0;
    for (int c = 0; c < pNUM_CHANNELS; c++) begin
      if (int'(ch_sel) == c) begin
        cnt_ext = 32'(count[c]);
`ifdef STAT_MATCH_TIMESTAMP_EN
        ts_ext  = 32'(ts_cap[c]);
`endif
        case (reg_sel)
          3'd0: begin
            if (bcnt == 32'd0)      rd_mux = 8'(pattern[c]);
            else if (bcnt == 32'd1) rd_mux = 8'(mask[c]);
          end
          3'd1: if (bcnt == 32'd0) rd_mux = {6'b0, mode[c]};
          3'd2: begin
            if (bcnt == 32'd0)      rd_mux = {7'b0, flag[c]};
            else if (bcnt == 32'd1) rd_mux = 8'(value[c]);
          end
          3'd3: if (bcnt < 32'd4) rd_mux = cnt_ext[{bsel, 3'b000} +: 8];
          3'd4: if (bcnt < 32'd4) rd_mux = ts_ext[{bsel, 3'b000} +: 8];
          default: rd_mux = 8'h00;
        endcase
      end
    end
  end

  // Registered read data, valid the cycle after a selected read strobe and 0 otherwise
  always_ff @(posedge cwusb_clk or posedge reset_i) begin
    if (reset_i)                     bus.read_data <= 8'h00;
    else if (bus.reg_read && selected) bus.read_data <= rd_mux;
    else                             bus.read_data <= 8'h00;
  end

endmodule

// File: tb/tb_reg_usb_stat_match.sv
// Directed bench for reg_usb_stat_match: register reads go through an
// expected-value scoreboard queue, flag/pulse outputs are compared directly.
module tb_reg_usb_stat_match;
  localparam int NCH = 4;
  localparam int SW  = 5;
  localparam int CW  = 8;
  localparam int TW  = 24;
  localparam int BW  = 7;
`ifdef STAT_MATCH_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif

  logic           cwusb_clk = 1'b0;
  logic           reset_i;
  logic           I_reg_arm;
  logic [SW-1:0]  I_fe_capture_stat;
  logic [NCH-1:0] O_match, O_match_pulse;
  logic           O_match_any, selected;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    string      tag;
    logic [7:0] value;
  } exp_t;
  exp_t sbq[$];

  reg_usb_stat_match_if #(.pBYTECNT_SIZE(BW)) bus ();

  reg_usb_stat_match #(
    .pNUM_CHANNELS(NCH), .pSTAT_WIDTH(SW), .pCOUNT_WIDTH(CW),
    .pTIMESTAMP_WIDTH(TW), .pBYTECNT_SIZE(BW), .pSELECT(2'b10)
  ) dut (
    .cwusb_clk(cwusb_clk), .reset_i(reset_i), .bus(bus),
    .I_reg_arm(I_reg_arm), .I_fe_capture_stat(I_fe_capture_stat),
    .O_match(O_match), .O_match_any(O_match_any),
    .O_match_pulse(O_match_pulse), .selected(selected)
  );

  always #5 cwusb_clk = ~cwusb_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic arm, input logic [SW-1:0] stat);
    I_reg_arm = arm;
    I_fe_capture_stat = stat;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge cwusb_clk);
  endtask

  task automatic writeReg(input int ch, input int rg, input int bc, input logic [7:0] d);
    bus.reg_address   = {1'b0, 2'b10, 2'(ch), 3'(rg)};
    bus.reg_bytecnt   = 7'(bc);
    bus.write_data    = d;
    bus.reg_addrvalid = 1'b1;
    bus.reg_write     = 1'b1;
    @(negedge cwusb_clk);
    bus.reg_write     = 1'b0;
    bus.reg_addrvalid = 1'b0;
  endtask

  task automatic readReg(input int ch, input int rg, input int bc, input logic [7:0] exp, input string tag);
    exp_t e;
    e.tag = tag;
    e.value = exp;
    sbq.push_back(e);
    bus.reg_address   = {1'b0, 2'b10, 2'(ch), 3'(rg)};
    bus.reg_bytecnt   = 7'(bc);
    bus.reg_addrvalid = 1'b1;
    bus.reg_read      = 1'b1;
    @(negedge cwusb_clk);
    bus.reg_read      = 1'b0;
    bus.reg_addrvalid = 1'b0;
    e = sbq.pop_front();
    checkOutput(e.tag, 32'(bus.read_data), 32'(e.value));
  endtask

  initial begin
    reset_i = 1'b1;
    applyStimulus(1'b1, 5'h00);
    bus.reg_address = 8'h00; bus.reg_bytecnt = '0; bus.write_data = 8'h00;
    bus.reg_read = 1'b0; bus.reg_write = 1'b0; bus.reg_addrvalid = 1'b0;
    tick(1);
    checkOutput("reset_match", 32'(O_match), 32'd0);
    checkOutput("reset_pulse", 32'(O_match_pulse), 32'd0);
    checkOutput("reset_rdata", 32'(bus.read_data), 32'd0);

    // Combinational block select
    bus.reg_addrvalid = 1'b1;
    bus.reg_address = 8'h40;
    #1 checkOutput("selected_hit", 32'(selected), 32'd1);
    bus.reg_address = 8'h20;
    #1 checkOutput("selected_miss", 32'(selected), 32'd0);
    bus.reg_addrvalid = 1'b0;

    // Reset default: arm held high through reset, first edge is the arm edge
    tick(1);
    reset_i = 1'b0;
    tick(1);
    checkOutput("edge_cycle_nomatch", 32'(O_match[0]), 32'd0);
    tick(1);
    checkOutput("ch0_default_match", 32'(O_match[0]), 32'd1);
    checkOutput("ch0_default_pulse", 32'(O_match_pulse[0]), 32'd1);
    checkOutput("match_any", 32'(O_match_any), 32'd1);
    tick(1);
    checkOutput("ch0_pulse_one_cycle", 32'(O_match_pulse[0]), 32'd0);
    readReg(0, 2, 1, 8'h00, "ch0_status_value");
    readReg(0, 2, 0, 8'h01, "ch0_status_flag");
    tick(1);
    checkOutput("rdata_idle", 32'(bus.read_data), 32'd0);
    bus.reg_address = 8'h22; bus.reg_addrvalid = 1'b1; bus.reg_read = 1'b1;
    tick(1);
    bus.reg_read = 1'b0; bus.reg_addrvalid = 1'b0;
    checkOutput("unselected_read", 32'(bus.read_data), 32'd0);

    // Mode 0 on ch1
    applyStimulus(1'b0, 5'h00);
    tick(1);
    writeReg(1, 0, 0, 8'h0A);
    writeReg(1, 0, 1, 8'h1F);
    readReg(1, 0, 0, 8'h0A, "ch1_pattern");
    readReg(1, 0, 1, 8'h1F, "ch1_mask");
    readReg(1, 0, 2, 8'h00, "ch1_pattern_b2");
    readReg(1, 2, 0, 8'h00, "ch1_cleared_by_pattern");
    writeReg(1, 6, 0, 8'hFF);
    readReg(1, 6, 0, 8'h00, "ch1_reserved");
    applyStimulus(1'b1, 5'h00);
    tick(1);
    tick(4);
    applyStimulus(1'b1, 5'h0A);
    tick(1);
    checkOutput("m0_flag", 32'(O_match[1]), 32'd1);
    checkOutput("m0_pulse", 32'(O_match_pulse[1]), 32'd1);
    applyStimulus(1'b1, 5'h00);
    tick(3);
    applyStimulus(1'b1, 5'h0A);
    tick(1);
    checkOutput("m0_no_second_pulse", 32'(O_match_pulse[1]), 32'd0);
    applyStimulus(1'b0, 5'h00);
    tick(1);
    readReg(1, 2, 0, 8'h01, "m0_status_flag");
    readReg(1, 2, 1, 8'h0A, "m0_status_value");
    readReg(1, 3, 0, 8'h02, "m0_count_b0");
    readReg(1, 3, 1, 8'h00, "m0_count_b1");
    readReg(1, 4, 0, TS_EN ? 8'h04 : 8'h00, "m0_ts_b0");
    readReg(1, 4, 1, 8'h00, "m0_ts_b1");
    readReg(1, 4, 2, 8'h00, "m0_ts_b2");

    // Mode 1 on ch2 and mode 2 on ch3, same pattern/mask
    writeReg(2, 0, 0, 8'h01);
    writeReg(2, 0, 1, 8'h03);
    writeReg(2, 1, 0, 8'h01);
    writeReg(3, 0, 0, 8'h01);
    writeReg(3, 0, 1, 8'h03);
    writeReg(3, 1, 0, 8'h02);
    readReg(2, 1, 0, 8'h01, "ch2_mode");
    readReg(3, 1, 0, 8'h02, "ch3_mode");
    applyStimulus(1'b1, 5'h00);
    tick(1);
    checkOutput("rearm_clears_ch1", 32'(O_match[1]), 32'd0);
    applyStimulus(1'b1, 5'h01); tick(1);
    applyStimulus(1'b1, 5'h01); tick(1);
    applyStimulus(1'b1, 5'h00); tick(1);
    applyStimulus(1'b1, 5'h05); tick(1);
    applyStimulus(1'b0, 5'h00); tick(1);
    readReg(2, 3, 0, 8'h03, "m1_count");
    readReg(2, 2, 1, 8'h05, "m1_value");
    readReg(2, 4, 0, TS_EN ? 8'h03 : 8'h00, "m1_ts");
    readReg(3, 3, 0, 8'h02, "m2_count");
    readReg(3, 2, 1, 8'h01, "m2_value");
    readReg(3, 2, 0, 8'h01, "m2_flag");
    readReg(3, 4, 0, 8'h00, "m2_ts");

    // Counter saturation on ch3 with mask 0
    writeReg(3, 0, 0, 8'h00);
    writeReg(3, 0, 1, 8'h00);
    writeReg(3, 1, 0, 8'h00);
    applyStimulus(1'b1, 5'h00);
    tick(300);
    applyStimulus(1'b0, 5'h00);
    tick(1);
    readReg(3, 3, 0, 8'hFF, "sat_count_b0");
    readReg(3, 3, 1, 8'h00, "sat_count_b1");

    // CLEAR write in the same cycle as a match
    writeReg(0, 0, 0, 8'h07);
    applyStimulus(1'b1, 5'h00);
    tick(3);
    applyStimulus(1'b1, 5'h07);
    writeReg(0, 5, 0, 8'h00);
    applyStimulus(1'b1, 5'h00);
    checkOutput("clear_vs_match_flag", 32'(O_match[0]), 32'd0);
    checkOutput("clear_vs_match_pulse", 32'(O_match_pulse[0]), 32'd0);
    readReg(0, 3, 0, 8'h00, "clear_vs_match_count");
    applyStimulus(1'b1, 5'h07);
    tick(1);
    checkOutput("ch0_match_after_clear", 32'(O_match[0]), 32'd1);
    applyStimulus(1'b1, 5'h00);
    readReg(0, 3, 0, 8'h01, "ch0_count_after_clear");

    // Re-arm edge coinciding with a match
    applyStimulus(1'b0, 5'h00);
    tick(1);
    applyStimulus(1'b1, 5'h07);
    tick(1);
    checkOutput("rearm_match_discarded", 32'(O_match), 32'd0);
    checkOutput("rearm_any", 32'(O_match_any), 32'd0);
    applyStimulus(1'b1, 5'h00);
    readReg(0, 3, 0, 8'h00, "rearm_ch0_count");
    readReg(0, 2, 0, 8'h00, "rearm_ch0_flag");

    // Asynchronous reset mid-capture, no clock edge in between
    checkOutput("pre_reset_ch3", 32'(O_match[3]), 32'd1);
    #2 reset_i = 1'b1;
    #1 checkOutput("async_reset_match", 32'(O_match), 32'd0);
    checkOutput("async_reset_any", 32'(O_match_any), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/reg_usb_stat_match.md
# reg_usb_stat_match

Parametrised multi-channel successor to the single-channel USB STAT matcher in the PW-USB register block. It provides `pNUM_CHANNELS` independent pattern/mask comparators on the front-end capture status bus. Each channel supports first-match, last-match or edge-count mode, with saturating match counters and an optional arm-relative timestamp. It sits on the `usb_reg_main` register bus beside the other PW-USB register blocks. It runs entirely in one clock domain; `I_fe_capture_stat` and `I_reg_arm` arrive already synchronised.

## Interface
Parameters:
- `pNUM_CHANNELS`, 4: number of match channels (1..4).
- `pSTAT_WIDTH`, 5: status bus width (1..8).
- `pCOUNT_WIDTH`, 16: per-channel match counter width (8..32).
- `pTIMESTAMP_WIDTH`, 24: timestamp counter width (8..32).
- `pBYTECNT_SIZE`, 7: register byte-count width.
- `pSELECT`, 2'b10: block select value compared against `reg_address[6:5]`.

Ports:
- `cwusb_clk` in 1: sole clock.
- `reset_i` in 1: asynchronous, active-high reset.
- `reg_address` in 8: register address.
- `reg_bytecnt` in `pBYTECNT_SIZE`: byte index within a register.
- `read_data` out 8: registered read data.
- `write_data` in 8: write data.
- `reg_read` in 1: read strobe.
- `reg_write` in 1: write strobe.
- `reg_addrvalid` in 1: address valid.
- `I_reg_arm` in 1: arm level.
- `I_fe_capture_stat` in `pSTAT_WIDTH`: status bus under test.
- `O_match` out `pNUM_CHANNELS`: per-channel captured flags.
- `O_match_any` out 1: OR of `O_match`.
- `O_match_pulse` out `pNUM_CHANNELS`: one-cycle pulse when a channel's captured flag sets.
- `selected` out 1: `reg_addrvalid & (reg_address[6:5]==pSELECT)`; combinational.

## Operation
- Address decode: `reg_address[4:3]` is the channel; `reg_address[2:0]` is the register. Channels at or above `pNUM_CHANNELS` read 0 and ignore writes.
- Register 0, PATTERN (read/write): byte 0 = pattern, byte 1 = mask, each low `pSTAT_WIDTH` bits. A write with `reg_bytecnt==0` also clears that channel.
- Register 1, MODE (read/write) [1:0]:
  - 0 first-match: capture the value once, then hold.
  - 1 last-match: recapture on every match cycle.
  - 2 edge-count: count 0→1 transitions of the match condition and capture on the first one.
  - 3 behaves as 0.
- Register 2, STATUS (read-only): byte 0 bit0 = captured flag; byte 1 = captured status value.
- Register 3, COUNT (read-only): little-endian bytes.
- Register 4, TIMESTAMP (read-only): captured timestamp bytes.
- Register 5, CLEAR (write-only): any write clears the channel.
- Registers 6–7 are reserved: they read 0 and ignore writes.
- Reads of bytes beyond a field's width return 0.
- Match condition: `(I_fe_capture_stat & mask) == (pattern & mask)`. A mask of 0 matches every cycle.
- Matches are evaluated only while `I_reg_arm`=1 and not in the arm-edge cycle.
- Arm edge = `I_reg_arm` & ~`arm_r`. On an arm edge, all channels clear (flag, value, count, timestamp) and the timestamp counter is set to 0.
- COUNT increments on each evaluated match cycle in modes 0/1, and on each rising match edge in mode 2. It saturates at all-ones.
- Timestamp counter: increments each armed cycle after the arm edge, saturates, and holds while disarmed.
- Precedence, highest first: reset, then arm edge, then channel clear (CLEAR write or PATTERN byte-0 write), then match update. A match in a clearing cycle is discarded.
- Reset values:
  - all outputs 0;
  - pattern 0;
  - mask all-ones;
  - mode 0;
  - flags, counts, timestamps 0;
  - `arm_r` 0.

## Timing
- `read_data` is valid on the cycle after `reg_read` with `selected`; otherwise it is 0.
- Writes take effect at the clock edge on which `reg_write` is sampled. A new pattern or mask is used from the next cycle.
- A match sampled at edge N sets `O_match` after edge N. `O_match_pulse` is high for exactly that one cycle.
- A match sampled k cycles after the arm-edge cycle captures timestamp k-1.
- Asserting reset mid-capture clears everything immediately, with no clock required.

## Configuration
- `STAT_MATCH_TIMESTAMP_EN` defined: the timestamp counter and the per-channel captured timestamps are implemented.
- `STAT_MATCH_TIMESTAMP_EN` undefined: no timestamp logic is built; TIMESTAMP reads return 0. All other behaviour is identical.

## Test plan
- Reset default: release reset with `I_reg_arm`=1 and stat=5'h00 → channel 0 does not match (mask 5'h1F, pattern 0 matches 0 only after the arm edge). From the cycle after the edge, `O_match[0]`=1, STATUS byte1=0x00.
- Mode 0: ch1 pattern 0x0A, mask 0x1F; arm; drive 0x0A at cycle 5 and 0x0A again at cycle 9 → flag set, value 0x0A, COUNT=2, TIMESTAMP=4 (first-match retained).
- Mode 1 vs 2: ch2 mask 0x03, pattern 0x01; drive 0x01,0x01,0x00,0x05 → mode 1 COUNT=3 with value 0x05; mode 2 COUNT=2.
- Saturation: `pCOUNT_WIDTH`=8, mask 0 on ch3, armed 300 cycles → COUNT=0xFF.
- Simultaneous: CLEAR write to ch0 in the same cycle as a match → flag stays 0 and COUNT=0. A re-arm edge coinciding with a match → all channels 0.
- Macro off: build without `STAT_MATCH_TIMESTAMP_EN`, repeat the mode-0 test → TIMESTAMP bytes read 0 and all other results unchanged.
